rotating_xbar_sched: RTL and testbench



---
 rtl/rotating_xbar_sched.sv | 139 +++++++++++++
 tb/tb_rotating_xbar_sched.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rotating_xbar_sched.sv
// Round-robin scheduler producing start_select for a rotating crossbar; the granted requester lands on lane 0.
// Optional protocol checker and sticky proto_err_o port enabled by ROTATING_XBAR_SCHED_ASSERT_EN.
`timescale 1ns/1ps

module rotating_xbar_sched #(
   parameter int unsigned NUM_DATA = 4,
   parameter int unsigned SEL_W    = $clog2(NUM_DATA)
) (
   input  logic                clk_i,
   input  logic                arst_ni,
   input  logic [NUM_DATA-1:0] req_valid_i,
   output logic [NUM_DATA-1:0] req_ready_o,
   output logic [SEL_W-1:0]    start_select_o,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic                busy_o
`ifdef ROTATING_XBAR_SCHED_ASSERT_EN
   ,
   output logic                proto_err_o
`endif
);

   typedef enum logic {IDLE, HOLD} state_e;

   state_e              state_q, state_d;
   logic [SEL_W-1:0]    ptr_q, ptr_d;
   logic [SEL_W-1:0]    sel_q, sel_d;

   logic [NUM_DATA-1:0] sel_onehot;
   logic [NUM_DATA-1:0] arb_req;
   logic [SEL_W-1:0]    arb_base;
   logic [SEL_W-1:0]    scan_idx;
   logic [SEL_W-1:0]    winner;
   logic                found;

   assign sel_onehot     = NUM_DATA'(1) << sel_q;
   assign start_select_o = sel_q;

   // In HOLD the scan restarts just past the held lane and excludes it, so a handshake can chain.
   always_comb begin
      arb_base = ptr_q;
      arb_req  = req_valid_i;
      if (state_q == HOLD) begin
         arb_base = sel_q + SEL_W'(1);
         arb_req  = req_valid_i & ~sel_onehot;
      end
      winner   = '0;
      found    = 1'b0;
      scan_idx = '0;
      for (int unsigned i = 0; i < NUM_DATA; i++) begin
         scan_idx = arb_base + SEL_W'(i);
         if (!found && arb_req[scan_idx]) begin
            winner = scan_idx;
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      sel_d       = sel_q;
      req_ready_o = '0;
      out_valid_o = 1'b0;
      busy_o      = 1'b0;
      case (state_q)
         IDLE: begin
            if (found) begin
               sel_d   = winner;
               state_d = HOLD;
            end
         end
         HOLD: begin
            out_valid_o = 1'b1;
            busy_o      = 1'b1;
            req_ready_o = sel_onehot & {NUM_DATA{out_ready_i}};
            if (out_ready_i) begin
               ptr_d = sel_q + SEL_W'(1);
               if (found) begin
                  sel_d = winner;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
      end
   end

`ifdef ROTATING_XBAR_SCHED_ASSERT_EN
   logic err_q, err_d;
   logic vld_prev_q, vld_prev_d;
   logic hs_prev_q, hs_prev_d;
   logic cond_drop, cond_fall;

   // Held requester dropping valid, or lane 0 valid vanishing without an accept.
   always_comb begin
      cond_drop  = (state_q == HOLD) && !req_valid_i[sel_q];
      cond_fall  = vld_prev_q && !out_valid_o && !hs_prev_q;
      vld_prev_d = out_valid_o;
      hs_prev_d  = out_valid_o & out_ready_i;
      err_d      = err_q | cond_drop | cond_fall;
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         err_q      <= 1'b0;
         vld_prev_q <= 1'b0;
         hs_prev_q  <= 1'b0;
      end else begin
         err_q      <= err_d;
         vld_prev_q <= vld_prev_d;
         hs_prev_q  <= hs_prev_d;
      end
   end

   assign proto_err_o = err_q;

`ifndef SYNTHESIS
   always @(posedge clk_i) begin
      if (arst_ni && cond_drop) $error("rotating_xbar_sched: held requester %0d dropped valid", sel_q);
      if (arst_ni && cond_fall) $error("rotating_xbar_sched: out_valid fell without handshake");
   end
`endif
`endif

endmodule

// File: tb/tb_rotating_xbar_sched.sv
// Directed and random self-checking bench for rotating_xbar_sched driving a modelled rotating crossbar.
`timescale 1ns/1ps

module tb_rotating_xbar_sched;
   localparam int unsigned N  = 4;
   localparam int unsigned SW = 2;

   logic          clk_i = 1'b0;
   logic          arst_ni;
   logic [N-1:0]  req_valid_i;
   logic [N-1:0]  req_ready_o;
   logic [SW-1:0] start_select_o;
   logic          out_valid_o;
   logic          out_ready_i;
   logic          busy_o;
`ifdef ROTATING_XBAR_SCHED_ASSERT_EN
   logic          proto_err_o;
`endif

   rotating_xbar_sched #(.NUM_DATA(N)) dut (
      .clk_i          (clk_i),
      .arst_ni        (arst_ni),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .start_select_o (start_select_o),
      .out_valid_o    (out_valid_o),
      .out_ready_i    (out_ready_i),
      .busy_o         (busy_o)
`ifdef ROTATING_XBAR_SCHED_ASSERT_EN
      ,
      .proto_err_o    (proto_err_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   // Crossbar model: output lane j carries input lane (sel + j) mod N.
   logic [7:0] data_in [N];
   logic [7:0] lane    [N];
   always_comb begin
      for (int j = 0; j < N; j++) lane[j] = data_in[(int'(start_select_o) + j) % N];
   end

   int n_checks = 0;
   int n_pass   = 0;
   int wait_cnt [N];
   logic [N-1:0] hs_seen;
   int g;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic mid();
      #4;
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         data_in[i]  = 8'(i);
         wait_cnt[i] = 0;
      end
      hs_seen     = '0;
      arst_ni     = 1'b0;
      req_valid_i = '0;
      out_ready_i = 1'b0;
      #12;
      chk("rst_valid", 32'(out_valid_o), 32'd0);
      chk("rst_sel",   32'(start_select_o), 32'd0);
      chk("rst_ready", 32'(req_ready_o), 32'd0);
      chk("rst_busy",  32'(busy_o), 32'd0);
`ifdef ROTATING_XBAR_SCHED_ASSERT_EN
      chk("rst_perr",  32'(proto_err_o), 32'd0);
`endif
      arst_ni = 1'b1;

      // 1: idle with no requests
      for (int i = 0; i < 10; i++) begin
         tick();
         mid();
         chk("idle_valid", 32'(out_valid_o), 32'd0);
         chk("idle_sel",   32'(start_select_o), 32'd0);
         chk("idle_ready", 32'(req_ready_o), 32'd0);
      end

      // 2: all requesting, consumer always ready
      tick();
      req_valid_i = 4'b1111;
      out_ready_i = 1'b1;
      mid();
      chk("rr_latency", 32'(out_valid_o), 32'd0);
      for (int i = 0; i < 8; i++) begin
         tick();
         if (i == 7) req_valid_i = 4'b1000;
         mid();
         chk("rr_sel",   32'(start_select_o), 32'(i % 4));
         chk("rr_ready", 32'(req_ready_o), 32'(1 << (i % 4)));
         chk("rr_valid", 32'(out_valid_o), 32'd1);
      end
      tick();
      req_valid_i = 4'b0000;
      mid();
      chk("rr_idle", 32'(out_valid_o), 32'd0);

      // 3: grant 1 moves ptr to 2, then 0011 wraps to 0 before 1
      tick();
      req_valid_i = 4'b0010;
      mid();
      chk("wr_pre_idle", 32'(out_valid_o), 32'd0);
      tick();
      mid();
      chk("wr_g1_sel",   32'(start_select_o), 32'd1);
      chk("wr_g1_ready", 32'(req_ready_o), 32'b0010);
      tick();
      req_valid_i = 4'b0011;
      mid();
      chk("wr_idle", 32'(out_valid_o), 32'd0);
      tick();
      req_valid_i = 4'b0011;
      mid();
      chk("wr_sel0",   32'(start_select_o), 32'd0);
      chk("wr_ready0", 32'(req_ready_o), 32'b0001);
      tick();
      req_valid_i = 4'b0010;
      mid();
      chk("wr_sel1",   32'(start_select_o), 32'd1);
      chk("wr_ready1", 32'(req_ready_o), 32'b0010);
      tick();
      req_valid_i = 4'b0000;
      mid();
      chk("wr_end_idle", 32'(out_valid_o), 32'd0);

      // 4: consumer stalls five cycles on requester 2
      tick();
      req_valid_i = 4'b0100;
      out_ready_i = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (i == 5) out_ready_i = 1'b1;
         mid();
         chk("st_sel",   32'(start_select_o), 32'd2);
         chk("st_valid", 32'(out_valid_o), 32'd1);
         chk("st_busy",  32'(busy_o), 32'd1);
         chk("st_ready", 32'(req_ready_o), (i == 5) ? 32'b0100 : 32'd0);
      end
      tick();
      req_valid_i = 4'b0000;
      mid();
      chk("st_idle_valid", 32'(out_valid_o), 32'd0);
      chk("st_idle_busy",  32'(busy_o), 32'd0);

      // 5: asynchronous reset while holding sel=3
      tick();
      req_valid_i = 4'b1000;
      out_ready_i = 1'b0;
      tick();
      mid();
      chk("ar_sel3", 32'(start_select_o), 32'd3);
      #1;
      arst_ni = 1'b0;
      #0.5;
      chk("ar_valid", 32'(out_valid_o), 32'd0);
      chk("ar_busy",  32'(busy_o), 32'd0);
      chk("ar_sel",   32'(start_select_o), 32'd0);
      #0.5;
      arst_ni     = 1'b1;
      req_valid_i = 4'b1001;
      out_ready_i = 1'b1;
      tick();
      mid();
      chk("ar_ptr0_sel",   32'(start_select_o), 32'd0);
      chk("ar_ptr0_ready", 32'(req_ready_o), 32'b0001);
      tick();
      req_valid_i = 4'b1000;
      mid();
      chk("ar_next_sel", 32'(start_select_o), 32'd3);
      tick();
      req_valid_i = 4'b0000;
      mid();
      chk("ar_idle", 32'(out_valid_o), 32'd0);

      // 6: random traffic through the crossbar model
      for (int c = 0; c < 10000; c++) begin
         tick();
         for (int i = 0; i < N; i++) begin
            if (hs_seen[i]) req_valid_i[i] = 1'b0;
            if (!req_valid_i[i] && ($urandom_range(1, 0) == 1)) begin
               req_valid_i[i] = 1'b1;
               data_in[i]     = 8'($urandom);
            end
         end
         out_ready_i = ($urandom_range(3, 0) != 0);
         hs_seen     = '0;
         mid();
         if (out_valid_o && out_ready_i) begin
            chk("rnd_onehot", 32'(req_ready_o), 32'(1 << start_select_o));
            g = -1;
            for (int i = 0; i < N; i++) if (req_ready_o[i]) g = i;
            if (g >= 0) begin
               chk("rnd_lane0", 32'(lane[0]), 32'(data_in[g]));
               chk("rnd_gvalid", 32'(req_valid_i[g]), 32'd1);
               hs_seen[g] = 1'b1;
               for (int i = 0; i < N; i++) begin
                  if (i == g) wait_cnt[i] = 0;
                  else if (req_valid_i[i]) begin
                     wait_cnt[i]++;
                     chk("rnd_fair", 32'(wait_cnt[i] <= N - 1), 32'd1);
                  end
               end
            end
         end else begin
            chk("rnd_noready", 32'(req_ready_o), 32'd0);
         end
      end
`ifdef ROTATING_XBAR_SCHED_ASSERT_EN
      chk("rnd_perr", 32'(proto_err_o), 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
